// File: rtl/aurora_frame_scheduler_if.sv
// Aurora lane scheduler bundle: hit input, register-read input, auto-read values and framed output.
// master = scheduler side; slave = the surrounding lane logic.
interface aurora_frame_scheduler_if #(
    parameter int SERVICE_FRAMES = 4
);
    localparam int N_AUTO = 2 * SERVICE_FRAMES;

    logic [N_AUTO*26-1:0] auto_read;
    logic                 rdreg_valid;
    logic                 rdreg_ready;
    logic [9:0]           rdreg_addr;
    logic [15:0]          rdreg_data;
    logic                 rdreg_drop;
    logic                 hit_valid;
    logic                 hit_ready;
    logic [63:0]          hit_data;
    logic [63:0]          data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic                 data_out_service;

    modport master (
        input  auto_read, rdreg_valid, rdreg_addr, rdreg_data, hit_valid, hit_data, data_out_ready,
        output rdreg_ready, rdreg_drop, hit_ready, data_out, data_out_valid, data_out_service
    );

    modport slave (
        output auto_read, rdreg_valid, rdreg_addr, rdreg_data, hit_valid, hit_data, data_out_ready,
        input  rdreg_ready, rdreg_drop, hit_ready, data_out, data_out_valid, data_out_service
    );
endinterface

// File: rtl/aurora_frame_scheduler.sv
// Merges hit frames/IDLE with periodic service and channel-bonding bursts; 1-cycle latency.
// Output register freezes frame, state, counters and FIFO pops while valid && !ready.
module aurora_frame_scheduler #(
    parameter int SERVICE_INTERVAL = 193,
    parameter int SERVICE_FRAMES   = 4,
    parameter int CB_INTERVAL      = 42,
    parameter int CB_FRAMES        = 4,
    parameter int RDREG_DEPTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    aurora_frame_scheduler_if.master  bus
);
    localparam int AW      = $clog2(RDREG_DEPTH);
    localparam int DW      = (SERVICE_INTERVAL > 1) ? $clog2(SERVICE_INTERVAL) : 1;
    localparam int SW      = (SERVICE_FRAMES > 1) ? $clog2(SERVICE_FRAMES) : 1;
    localparam int BW      = (CB_INTERVAL > 1) ? $clog2(CB_INTERVAL) : 1;
    localparam int CW      = (CB_FRAMES > 1) ? $clog2(CB_FRAMES) : 1;
    localparam int CB_LAST = (CB_FRAMES > 0) ? CB_FRAMES - 1 : 0;
    localparam bit CB_EN   = (CB_FRAMES > 0);

    localparam logic [63:0] IDLE_FRAME = 64'h1E00_0000_0000_0000;
    localparam logic [63:0] CB_FRAME   = {8'h78, 4'b0100, 52'h0};

    typedef enum logic [1:0] {ST_DATA, ST_SERVICE, ST_CB} state_t;

    state_t          state_q;
    logic [DW-1:0]   data_cnt_q;
    logic [SW-1:0]   svc_cnt_q;
    logic [BW-1:0]   burst_cnt_q;
    logic [CW-1:0]   cb_cnt_q;
    logic [63:0]     data_out_q;
    logic            valid_q;
    logic            service_q;

    logic [25:0]     mem_q [RDREG_DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     occ_q;
    logic            drop_q;

    logic            load;
    logic            full;
    logic            push;
    logic [1:0]      pop_n;
    logic [25:0]     e0;
    logic [25:0]     e1;
    logic [25:0]     auto_lo;
    logic [25:0]     auto_hi;
    logic [63:0]     svc_frame_d;

    assign load    = !valid_q || bus.data_out_ready;
    assign full    = (occ_q == (AW+1)'(RDREG_DEPTH));
    assign push    = bus.rdreg_valid && !full;
    assign e0      = mem_q[rd_ptr_q];
    assign e1      = mem_q[rd_ptr_q + AW'(1)];
    assign auto_lo = bus.auto_read[32'(svc_cnt_q)*52 +: 26];
    assign auto_hi = bus.auto_read[32'(svc_cnt_q)*52 + 26 +: 26];

    // Service frame content depends on FIFO occupancy at the load edge.
    always_comb begin
        pop_n       = 2'd0;
        svc_frame_d = {8'hB4, 4'h0, auto_lo, auto_hi};
        if (occ_q >= (AW+1)'(2)) begin
            svc_frame_d = {8'hD2, 4'h0, e0, e1};
            pop_n       = 2'd2;
        end else if (occ_q == (AW+1)'(1)) begin
            svc_frame_d = {8'h99, 4'h0, e0, auto_lo};
            pop_n       = 2'd1;
        end
        if (!(load && state_q == ST_SERVICE)) begin
            pop_n = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.rdreg_addr, bus.rdreg_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_ptr_q + AW'(pop_n);
            occ_q    <= occ_q + (AW+1)'(push) - (AW+1)'(pop_n);
            if (bus.rdreg_valid && full) begin
                drop_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_DATA;
            data_cnt_q  <= '0;
            svc_cnt_q   <= '0;
            burst_cnt_q <= '0;
            cb_cnt_q    <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            service_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            case (state_q)
                ST_DATA: begin
                    data_out_q <= bus.hit_valid ? bus.hit_data : IDLE_FRAME;
                    service_q  <= 1'b0;
                    if (data_cnt_q == DW'(SERVICE_INTERVAL - 1)) begin
                        data_cnt_q <= '0;
                        state_q    <= ST_SERVICE;
                    end else begin
                        data_cnt_q <= data_cnt_q + DW'(1);
                    end
                end
                ST_SERVICE: begin
                    data_out_q <= svc_frame_d;
                    service_q  <= 1'b1;
                    if (svc_cnt_q == SW'(SERVICE_FRAMES - 1)) begin
                        svc_cnt_q <= '0;
                        if (CB_EN && burst_cnt_q == BW'(CB_INTERVAL - 1)) begin
                            burst_cnt_q <= '0;
                            cb_cnt_q    <= '0;
                            state_q     <= ST_CB;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + BW'(1);
                            state_q     <= ST_DATA;
                        end
                    end else begin
                        svc_cnt_q <= svc_cnt_q + SW'(1);
                    end
                end
                default: begin
                    data_out_q <= CB_FRAME;
                    service_q  <= 1'b1;
                    if (cb_cnt_q == CW'(CB_LAST)) begin
                        cb_cnt_q <= '0;
                        state_q  <= ST_DATA;
                    end else begin
                        cb_cnt_q <= cb_cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    // Gated by reset so hit_ready reads 0 while the output register is held in reset.
    assign bus.hit_ready        = load && (state_q == ST_DATA) && bus.hit_valid && !reset;
    assign bus.rdreg_ready      = !full;
    assign bus.rdreg_drop       = drop_q;
    assign bus.data_out         = data_out_q;
    assign bus.data_out_valid   = valid_q;
    assign bus.data_out_service = service_q;
endmodule

// File: tb/tb_aurora_frame_scheduler.sv
// Directed bench for aurora_frame_scheduler with a small schedule (4 data, 2 service, CB every 2 bursts).
module tb_aurora_frame_scheduler;
    localparam int SI = 4, SF = 2, CBI = 2, CBF = 2, DEPTH = 4, NA = 4, PERIOD = 14;
    localparam logic [63:0] IDLE = 64'h1E00_0000_0000_0000;
    localparam logic [63:0] CBW  = {8'h78, 4'b0100, 52'h0};
    localparam logic [63:0] HB   = 64'hC0DE_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    aurora_frame_scheduler_if #(.SERVICE_FRAMES(SF)) bus();

    aurora_frame_scheduler #(
        .SERVICE_INTERVAL(SI), .SERVICE_FRAMES(SF), .CB_INTERVAL(CBI),
        .CB_FRAMES(CBF), .RDREG_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required to finish", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [25:0] auto_ent(input int i);
        return {10'(32'h100 + i), 16'(32'hA000 + i)};
    endfunction

    function automatic logic [25:0] rd_ent(input int i);
        return {10'(32'h200 + i), 16'(32'h5000 + i)};
    endfunction

    function automatic bit is_data(input int n);
        int p;
        p = n % PERIOD;
        return (p < 4) || (p >= 6 && p < 10);
    endfunction

    // {service, frame} expected at schedule position n with no hits and an empty FIFO
    function automatic logic [64:0] exp_sched(input int n);
        int p;
        int k;
        p = n % PERIOD;
        if (p >= 12) return {1'b1, CBW};
        if ((p >= 4 && p < 6) || (p >= 10 && p < 12)) begin
            k = (p < 6) ? p - 4 : p - 10;
            return {1'b1, 8'hB4, 4'h0, auto_ent(2*k), auto_ent(2*k+1)};
        end
        return {1'b0, IDLE};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rd(input bit v, input int i);
        logic [25:0] e;
        e = rd_ent(i);
        bus.rdreg_valid = v;
        bus.rdreg_addr  = e[25:16];
        bus.rdreg_data  = e[15:0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_frame(input string name, input int n, input logic [64:0] exp);
        n_checks++;
        if ({bus.data_out_service, bus.data_out} !== exp || bus.data_out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s frame %0d: got svc=%b valid=%b data=%h required svc=%b valid=1 data=%h",
                     name, n, bus.data_out_service, bus.data_out_valid, bus.data_out, exp[64], exp[63:0]);
        end
    endtask

    task automatic test_reset();
        bus.hit_valid = 1'b1;
        bus.hit_data = HB;
        bus.data_out_ready = 1'b1;
        set_rd(1'b0, 0);
        @(negedge clk);
        n_checks++; if (bus.data_out !== 64'h0) begin n_errors++; $display("FAIL reset data_out: got %h required 0", bus.data_out); end
        n_checks++; if (bus.data_out_valid !== 1'b0) begin n_errors++; $display("FAIL reset valid: got %b required 0", bus.data_out_valid); end
        n_checks++; if (bus.data_out_service !== 1'b0) begin n_errors++; $display("FAIL reset service: got %b required 0", bus.data_out_service); end
        n_checks++; if (bus.hit_ready !== 1'b0) begin n_errors++; $display("FAIL reset hit_ready: got %b required 0", bus.hit_ready); end
        n_checks++; if (bus.rdreg_ready !== 1'b1) begin n_errors++; $display("FAIL reset rdreg_ready: got %b required 1", bus.rdreg_ready); end
        n_checks++; if (bus.rdreg_drop !== 1'b0) begin n_errors++; $display("FAIL reset rdreg_drop: got %b required 0", bus.rdreg_drop); end
    endtask

    task automatic test_periodic();
        bus.hit_valid = 1'b0;
        bus.data_out_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 2*PERIOD; n++) begin
            tick();
            chk_frame("periodic", n, exp_sched(n));
        end
    endtask

    task automatic test_hits();
        int sent;
        logic [64:0] e;
        sent = 0;
        bus.hit_valid = 1'b1;
        bus.data_out_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 2*PERIOD; n++) begin
            bus.hit_data = HB + 64'(sent);
            #1;
            n_checks++;
            if (bus.hit_ready !== is_data(n)) begin
                n_errors++;
                $display("FAIL hits hit_ready %0d: got %b required %b", n, bus.hit_ready, is_data(n));
            end
            e = exp_sched(n);
            if (is_data(n)) begin
                e = {1'b0, HB + 64'(sent)};
                sent++;
            end
            tick();
            chk_frame("hits", n, e);
        end
        bus.hit_valid = 1'b0;
    endtask

    task automatic test_rdreg();
        logic [64:0] e;
        bus.hit_valid = 1'b0;
        bus.data_out_ready = 1'b1;
        do_reset();
        for (int n = 0; n < PERIOD; n++) begin
            set_rd(n < 3, n);
            tick();
            e = exp_sched(n);
            if (n == 4) e = {1'b1, 8'hD2, 4'h0, rd_ent(0), rd_ent(1)};
            if (n == 5) e = {1'b1, 8'h99, 4'h0, rd_ent(2), auto_ent(2)};
            chk_frame("rdreg", n, e);
        end
        set_rd(1'b0, 0);
    endtask

    task automatic test_backpressure();
        int sent;
        int n;
        bit mvalid;
        logic [64:0] mframe;
        bit rdy;
        bit ld;
        sent = 0;
        n = 0;
        mvalid = 1'b0;
        mframe = '0;
        bus.hit_valid = 1'b1;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            rdy = 1'($urandom_range(0, 1));
            bus.data_out_ready = rdy;
            bus.hit_data = HB + 64'h100 + 64'(sent);
            #1;
            ld = !mvalid || rdy;
            n_checks++;
            if (bus.hit_ready !== (ld && is_data(n))) begin
                n_errors++;
                $display("FAIL backpressure hit_ready cycle %0d: got %b required %b", c, bus.hit_ready, ld && is_data(n));
            end
            if (ld) begin
                mframe = exp_sched(n);
                if (is_data(n)) begin
                    mframe = {1'b0, HB + 64'h100 + 64'(sent)};
                    sent++;
                end
                n++;
                mvalid = 1'b1;
            end
            tick();
            chk_frame("backpressure", c, mframe);
        end
        bus.hit_valid = 1'b0;
        bus.data_out_ready = 1'b1;
    endtask

    task automatic test_overflow();
        logic [64:0] e;
        bus.hit_valid = 1'b0;
        bus.data_out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_rd(1'b1, i);
            tick();
            if (i == 3) begin
                n_checks++; if (bus.rdreg_ready !== 1'b0) begin n_errors++; $display("FAIL overflow ready after 4th: got %b required 0", bus.rdreg_ready); end
                n_checks++; if (bus.rdreg_drop !== 1'b0) begin n_errors++; $display("FAIL overflow early drop: got %b required 0", bus.rdreg_drop); end
            end
            if (i == 4) begin
                n_checks++; if (bus.rdreg_drop !== 1'b1) begin n_errors++; $display("FAIL overflow drop: got %b required 1", bus.rdreg_drop); end
            end
        end
        set_rd(1'b0, 0);
        repeat (3) tick();
        n_checks++; if (bus.rdreg_drop !== 1'b1) begin n_errors++; $display("FAIL overflow drop sticky: got %b required 1", bus.rdreg_drop); end
        chk_frame("overflow_hold", 0, {1'b0, IDLE});
        bus.data_out_ready = 1'b1;
        for (int n = 1; n < PERIOD; n++) begin
            tick();
            e = exp_sched(n);
            if (n == 4) e = {1'b1, 8'hD2, 4'h0, rd_ent(0), rd_ent(1)};
            if (n == 5) e = {1'b1, 8'hD2, 4'h0, rd_ent(2), rd_ent(3)};
            chk_frame("overflow", n, e);
        end
        n_checks++; if (bus.rdreg_drop !== 1'b1) begin n_errors++; $display("FAIL overflow drop end: got %b required 1", bus.rdreg_drop); end
        n_checks++; if (bus.rdreg_ready !== 1'b1) begin n_errors++; $display("FAIL overflow ready end: got %b required 1", bus.rdreg_ready); end
    endtask

    task automatic test_reset_mid();
        bus.hit_valid = 1'b0;
        bus.data_out_ready = 1'b1;
        do_reset();
        repeat (6) tick();
        chk_frame("mid_pre", 5, exp_sched(5));
        bus.data_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rd(1'b1, 8 + i);
            tick();
        end
        set_rd(1'b0, 0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.data_out !== 64'h0) begin n_errors++; $display("FAIL mid reset data_out: got %h required 0", bus.data_out); end
        n_checks++; if (bus.data_out_valid !== 1'b0) begin n_errors++; $display("FAIL mid reset valid: got %b required 0", bus.data_out_valid); end
        n_checks++; if (bus.data_out_service !== 1'b0) begin n_errors++; $display("FAIL mid reset service: got %b required 0", bus.data_out_service); end
        @(negedge clk);
        reset = 1'b0;
        bus.data_out_ready = 1'b1;
        for (int n = 0; n < PERIOD; n++) begin
            tick();
            chk_frame("after_mid_reset", n, exp_sched(n));
        end
    endtask

    initial begin
        for (int i = 0; i < NA; i++) begin
            bus.auto_read[i*26 +: 26] = auto_ent(i);
        end
        test_reset();
        test_periodic();
        test_hits();
        test_rdreg();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
